// File: rtl/ram_write_buffer_if.sv
//------------------------------------------------------------------------------
// Module : ram_write_buffer_if
// Brief  : Cache request / read-return and RAM ce-ack bundle for ram_write_buffer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_ce_i;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [3:0]    req_sel_i;
    logic [DW-1:0] req_data_i;
    logic          stall_o;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          ram_ce_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_sel_o;
    logic [DW-1:0] ram_data_o;
    logic          ram_ack_i;
    logic [DW-1:0] ram_data_i;

    modport slave (
        input  req_ce_i, req_we_i, req_addr_i, req_sel_i, req_data_i,
        input  ram_ack_i, ram_data_i,
        output stall_o, rd_data_o, rd_valid_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );

    modport master (
        output req_ce_i, req_we_i, req_addr_i, req_sel_i, req_data_i,
        output ram_ack_i, ram_data_i,
        input  stall_o, rd_data_o, rd_valid_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );
endinterface

`default_nettype wire

// File: rtl/ram_write_buffer.sv
//------------------------------------------------------------------------------
// Module : ram_write_buffer
// Brief  : Write-through FIFO between data cache and RAM; reads drain behind
//          queued writes. Define WBUF_READ_FWD_EN to serve full-word reads
//          directly from matching queued writes.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  wire               clk,
    input  wire               rst,
    ram_write_buffer_if.slave bus
);
    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [3:0]       r_sel  [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [c_PTR_W-1:0] r_head, r_tail;
    logic [c_PTR_W:0]   r_count, w_count_nxt;

    state_t        r_state;
    logic          r_ram_ce, r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [3:0]    r_ram_sel;
    logic [DW-1:0] r_ram_data;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_fwd_done;

    logic          w_is_rd, w_enq, w_wr_ack, w_rd_ack, w_rd_pend, w_fwd, w_stall;
    logic          w_fwd_hit;
    logic [DW-1:0] w_fwd_data;

    assign w_is_rd   = bus.req_ce_i & ~bus.req_we_i;
    assign w_enq     = bus.req_ce_i & bus.req_we_i & (r_count != c_FULL);
    assign w_wr_ack  = (r_state == S_WR) & r_ram_ce & bus.ram_ack_i;
    assign w_rd_ack  = (r_state == S_RD) & r_ram_ce & bus.ram_ack_i;
    // r_fwd_done marks the cycle after a forwarded read: the request is still
    // held by the cache but has already been answered.
    assign w_fwd     = w_is_rd & w_fwd_hit & ~r_fwd_done;
    assign w_rd_pend = w_is_rd & ~r_fwd_done;

`ifdef WBUF_READ_FWD_EN
    logic [c_PTR_W-1:0] w_idx;

    // Scan oldest to newest so the newest full-word match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if (((c_PTR_W+1)'(i) < r_count) && (r_sel[w_idx] == 4'hF) &&
                (r_addr[w_idx][AW-1:2] == bus.req_addr_i[AW-1:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    always_comb begin
        w_count_nxt = r_count;
        if (w_enq && !w_wr_ack)
            w_count_nxt = r_count + c_CNT_ONE;
        else if (!w_enq && w_wr_ack)
            w_count_nxt = r_count - c_CNT_ONE;
    end

    always_comb begin
        w_stall = 1'b0;
        if (bus.req_ce_i) begin
            if (bus.req_we_i)
                w_stall = (r_count == c_FULL);
            else
                w_stall = ~(w_rd_ack | r_fwd_done);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= bus.req_addr_i;
            r_sel[r_tail]  <= bus.req_sel_i;
            r_data[r_tail] <= bus.req_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_ram_ce   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_sel  <= '0;
            r_ram_data <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_fwd_done <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_fwd_done <= w_fwd;
            r_rd_valid <= 1'b0;
            if (w_enq)
                r_tail <= r_tail + c_PTR_ONE;
            if (w_wr_ack)
                r_head <= r_head + c_PTR_ONE;
            if (w_fwd) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= w_fwd_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state    <= S_WR;
                        r_ram_ce   <= 1'b1;
                        r_ram_we   <= 1'b1;
                        r_ram_addr <= r_addr[r_head];
                        r_ram_sel  <= r_sel[r_head];
                        r_ram_data <= r_data[r_head];
                    end else if (w_rd_pend) begin
                        r_state    <= S_RD;
                        r_ram_ce   <= 1'b1;
                        r_ram_we   <= 1'b0;
                        r_ram_addr <= bus.req_addr_i;
                        r_ram_sel  <= 4'hF;
                        r_ram_data <= '0;
                    end
                end
                S_WR: begin
                    // ce low here is the gap cycle after an ack: load the new head.
                    if (!r_ram_ce) begin
                        r_ram_ce   <= 1'b1;
                        r_ram_we   <= 1'b1;
                        r_ram_addr <= r_addr[r_head];
                        r_ram_sel  <= r_sel[r_head];
                        r_ram_data <= r_data[r_head];
                    end else if (bus.ram_ack_i) begin
                        r_ram_ce <= 1'b0;
                        r_state  <= (w_count_nxt != '0) ? S_WR : S_IDLE;
                    end
                end
                S_RD: begin
                    if (bus.ram_ack_i) begin
                        r_ram_ce   <= 1'b0;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= bus.ram_data_i;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_o    = w_stall;
    assign bus.rd_data_o  = r_rd_data;
    assign bus.rd_valid_o = r_rd_valid;
    assign bus.ram_ce_o   = r_ram_ce;
    assign bus.ram_we_o   = r_ram_we;
    assign bus.ram_addr_o = r_ram_addr;
    assign bus.ram_sel_o  = r_ram_sel;
    assign bus.ram_data_o = r_ram_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_write_buffer.sv
//------------------------------------------------------------------------------
// Module : tb_ram_write_buffer
// Brief  : Directed self-checking bench for ram_write_buffer with a RAM responder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_write_buffer;
    logic clk = 1'b0;
    logic rst;

    ram_write_buffer_if #(.AW(32), .DW(32)) bus ();

    ram_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          ack_hold = 1'b0;
    bit          inj_ack = 1'b0;
    int          ack_lat = 3;
    int          wait_cnt = 0;
    logic [31:0] rd_val = '0;
    logic [68:0] log_q [$];     // {we, sel, addr, data} of each RAM-acked request
    int          stall_total = 0;
    int          base;
    int          s0;

    // RAM responder: acks ack_lat cycles after ce rises, unless held off.
    initial begin
        bus.ram_ack_i  = 1'b0;
        bus.ram_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.ram_ack_i = inj_ack;
            if (bus.ram_ce_o && !ack_hold) begin
                wait_cnt++;
                if (wait_cnt >= ack_lat) begin
                    bus.ram_ack_i  = 1'b1;
                    bus.ram_data_i = rd_val;
                    wait_cnt       = 0;
                    log_q.push_back({bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o, bus.ram_data_o});
                end
            end else if (!bus.ram_ce_o) begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) if (bus.stall_o === 1'b1) stall_total++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic ce, input logic we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] data);
        bus.req_ce_i   = ce;
        bus.req_we_i   = we;
        bus.req_addr_i = addr;
        bus.req_sel_i  = sel;
        bus.req_data_i = data;
    endtask

    task automatic wait_idle(input string tag, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!bus.ram_ce_o && dut.r_count == 3'd0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_nostall(input string tag, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!bus.stall_o) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, done, 1);
    endtask

    initial begin
        bit ok;
        bit s;
        int g;
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0);
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.stall_o, bus.rd_valid_o, bus.rd_data_o, bus.ram_ce_o, bus.ram_we_o,
                              bus.ram_addr_o, bus.ram_sel_o, bus.ram_data_o}, 104'd0);
        chk("reset_count", dut.r_count, 3'd0);

        // Single write, 3-cycle RAM latency
        step(1);
        base = log_q.size();
        s0   = stall_total;
        set_req(1, 1, 32'h100, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_accept_stall", bus.stall_o, 0);
        step(1);
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_count_after_accept", dut.r_count, 3'd1);
        step(1);
        @(negedge clk);
        chk("t1_ram_req", {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o, bus.ram_data_o},
            {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF});
        step(1);
        @(negedge clk);
        chk("t1_ram_hold", {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o, bus.ram_data_o},
            {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF});
        wait_idle("t1_drain", 20);
        chk("t1_log", {log_q.size() - base, log_q[base]}, {32'd1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF});
        chk("t1_never_stalled", stall_total - s0, 0);

        // Five back-to-back writes with ack withheld
        step(1);
        ack_hold = 1'b1;
        ack_lat  = 1;
        base     = log_q.size();
        for (int i = 1; i <= 4; i++) begin
            set_req(1, 1, 32'(32'h1000 + 4 * i), 4'hF, 32'(32'hA0000000 + i));
            @(negedge clk);
            chk($sformatf("t2_accept%0d", i), bus.stall_o, 0);
            step(1);
        end
        set_req(1, 1, 32'h1014, 4'hF, 32'hA0000005);
        @(negedge clk);
        chk("t2_full_stall", bus.stall_o, 1);
        step(3);
        @(negedge clk);
        chk("t2_full_hold", {bus.stall_o, dut.r_count}, {1'b1, 3'd4});
        ack_hold = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            @(negedge clk);
            if (bus.ram_ack_i) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t2_first_ack_seen", ok, 1);
        chk("t2_stall_in_ack_cycle", bus.stall_o, 1);
        step(1);
        @(negedge clk);
        chk("t2_fifth_accepted", bus.stall_o, 0);
        step(1);
        set_req(0, 0, 0, 0, 0);
        wait_idle("t2_drain", 60);
        chk("t2_log_size", log_q.size() - base, 5);
        for (int i = 1; i <= 5; i++)
            chk($sformatf("t2_order%0d", i), log_q[base + i - 1],
                {1'b1, 4'hF, 32'(32'h1000 + 4 * i), 32'(32'hA0000000 + i)});

        // Two writes then a read that must wait for the drain
        step(1);
        ack_lat = 2;
        rd_val  = 32'h12345678;
        base    = log_q.size();
        set_req(1, 1, 32'h2000, 4'hF, 32'h1);
        step(1);
        set_req(1, 1, 32'h2004, 4'hF, 32'h2);
        step(1);
        set_req(1, 0, 32'h200, 4'h0, 32'h0);
        @(negedge clk);
        chk("t3_read_stall", bus.stall_o, 1);
        wait_nostall("t3_read_done", 60);
        chk("t3_rd_ack_cycle", {bus.ram_ce_o, bus.ram_we_o, bus.ram_ack_i}, 3'b101);
        chk("t3_log_order", {log_q.size() - base, log_q[base][63:32], log_q[base + 1][63:32], log_q[base + 2][68:32]},
            {32'd3, 32'h2000, 32'h2004, 1'b0, 4'hF, 32'h200});
        step(1);
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_rd_valid", {bus.rd_valid_o, bus.rd_data_o}, {1'b1, 32'h12345678});
        step(1);
        @(negedge clk);
        chk("t3_rd_pulse_end", {bus.rd_valid_o, bus.rd_data_o}, {1'b0, 32'h12345678});

        // Reset while a write waits for ack with three entries queued
        ack_hold = 1'b1;
        step(1);
        base = log_q.size();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1, 32'(32'h3000 + 4 * i), 4'hF, 32'(32'h30 + i));
            step(1);
        end
        set_req(0, 0, 0, 0, 0);
        step(2);
        @(negedge clk);
        chk("t4_pre_reset", {dut.r_count, bus.ram_ce_o, bus.ram_we_o}, {3'd3, 1'b1, 1'b1});
        inj_ack = 1'b1;
        step(1);
        rst = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_outputs", {bus.rd_valid_o, bus.rd_data_o, bus.ram_ce_o, bus.ram_we_o,
                               bus.ram_addr_o, bus.ram_sel_o, bus.ram_data_o, dut.r_count}, 106'd0);
        inj_ack = 1'b1;
        step(1);
        @(negedge clk);
        inj_ack = 1'b0;
        step(1);
        @(negedge clk);
        chk("t4_late_ack_ignored", {dut.r_count, bus.ram_ce_o, bus.rd_valid_o}, 5'd0);
        ack_hold = 1'b0;
        ack_lat  = 1;
        step(1);
        set_req(1, 1, 32'h4000, 4'h5, 32'h44);
        @(negedge clk);
        chk("t4_new_write_stall", bus.stall_o, 0);
        step(1);
        set_req(0, 0, 0, 0, 0);
        wait_idle("t4_drain", 20);
        chk("t4_new_write_log", {log_q.size() - base, log_q[log_q.size() - 1]},
            {32'd1, 1'b1, 4'h5, 32'h4000, 32'h44});

        // Pointer wrap: ten writes, 1-cycle ack
        step(1);
        base = log_q.size();
        for (int i = 0; i < 10; i++) begin
            set_req(1, 1, 32'(32'h5000 + 16 * i), 4'(i + 1), 32'(32'h5A5A0000 + 32'h111 * i));
            g = 0;
            do begin
                @(negedge clk);
                s = bus.stall_o;
                step(1);
                g++;
            end while (s && g < 50);
        end
        set_req(0, 0, 0, 0, 0);
        wait_idle("t5_drain", 200);
        chk("t5_log_size", log_q.size() - base, 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t5_entry%0d", i), log_q[base + i],
                {1'b1, 4'(i + 1), 32'(32'h5000 + 16 * i), 32'(32'h5A5A0000 + 32'h111 * i)});

        // Read of a queued full-word write
        @(negedge clk);
        ack_hold = 1'b1;
        ack_lat  = 1;
        rd_val   = 32'h0BADF00D;
        step(1);
        base = log_q.size();
        set_req(1, 1, 32'h300, 4'hF, 32'hCAFEF00D);
        step(1);
        set_req(1, 0, 32'h300, 4'h0, 32'h0);
        @(negedge clk);
        chk("t6_req_cycle_stall", bus.stall_o, 1);
`ifdef WBUF_READ_FWD_EN
        step(1);
        @(negedge clk);
        chk("t6_fwd_data", {bus.rd_valid_o, bus.rd_data_o, bus.stall_o}, {1'b1, 32'hCAFEF00D, 1'b0});
        step(1);
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_no_ram_read", {bus.rd_valid_o, bus.ram_ce_o, bus.ram_we_o}, 3'b011);
        ack_hold = 1'b0;
        wait_idle("t6_drain", 30);
        chk("t6_log_only_write", {log_q.size() - base, log_q[base][68]}, {32'd1, 1'b1});
`else
        step(3);
        @(negedge clk);
        chk("t6_wait_drain", {bus.stall_o, bus.rd_valid_o}, 2'b10);
        ack_hold = 1'b0;
        wait_nostall("t6_read_done", 40);
        step(1);
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_ram_read_data", {bus.rd_valid_o, bus.rd_data_o}, {1'b1, 32'h0BADF00D});
        chk("t6_log", {log_q.size() - base, log_q[base + 1][68:32]}, {32'd2, 1'b0, 4'hF, 32'h300});
`endif

        // Partial-sel match never forwards
        @(negedge clk);
        ack_hold = 1'b1;
        rd_val   = 32'h55667788;
        step(1);
        base = log_q.size();
        set_req(1, 1, 32'h304, 4'h3, 32'h11112222);
        step(1);
        set_req(1, 0, 32'h304, 4'h0, 32'h0);
        step(3);
        @(negedge clk);
        chk("t7_partial_no_fwd", {bus.stall_o, bus.rd_valid_o}, 2'b10);
        ack_hold = 1'b0;
        wait_nostall("t7_read_done", 40);
        chk("t7_log", {log_q.size() - base, log_q[base][68:64], log_q[base + 1][68:32]},
            {32'd2, 1'b1, 4'h3, 1'b0, 4'hF, 32'h304});
        step(1);
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t7_rd_data", {bus.rd_valid_o, bus.rd_data_o}, {1'b1, 32'h55667788});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
